// File: rtl/aes_spi_pkg.sv
// Shared constants for the SPI front end of the external AES core:
// frame geometry, counter width, FSM state encodings and legal Nk/Nr pairs.
package aes_spi_pkg;

  localparam int MSG_W = 128;
  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = 9'd255;
  localparam logic [CNT_W-1:0] CNT_ONE = 9'd1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD_MSG  = 3'd1;
  localparam state_t ST_LOAD_KEY  = 3'd2;
  localparam state_t ST_START     = 3'd3;
  localparam state_t ST_WAIT      = 3'd4;
  localparam state_t ST_SHIFT_OUT = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  localparam int NK_LEGAL [3] = '{4, 6, 8};
  localparam int NR_LEGAL [3] = '{10, 12, 14};

  // AES-128/192/256 each pair a key length with exactly one round count.
  function automatic bit nk_nr_legal(input int nk, input int nr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (NK_LEGAL[i] == nk && NR_LEGAL[i] == nr) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/spi_shift_in.sv
// Serial-to-parallel shifter: each enabled bit enters at the MSB, so the
// first bit received ends up in bit 0 once W bits have been shifted.
module spi_shift_in #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= {bit_i, data_q[W-1:1]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_aes_slave.sv
// SPI-style slave that collects a message and key LSB first, hands them to an
// external AES core, and streams the 128-bit result back out on SOMI.
module spi_aes_slave
  import aes_spi_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CSS,
  input  logic             SIMO,
  input  logic             mode,
  output logic             SOMI,
  output logic             aes_start,
  output logic             aes_mode,
  output logic [MSG_W-1:0] aes_msg,
  output logic [Nk*32-1:0] aes_key,
  input  logic             aes_done,
  input  logic [MSG_W-1:0] aes_result,
  output logic             busy,
  output logic             frame_err
);

  localparam int KEY_W = Nk * 32;
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_W - 2);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(MSG_W - 1);

  if (!nk_nr_legal(Nk, Nr)) begin : g_bad_params
    $error("spi_aes_slave: illegal Nk/Nr combination");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q;
  logic [MSG_W-1:0]   result_q;
  logic               somi_q, somi_d;
  logic               frame_err_q;
  logic               msg_shift, key_shift, load_result, abort;
  logic [6:0]         out_idx;

  // The IDLE->LOAD_MSG edge already carries message bit 0, so LOAD_MSG only
  // needs 127 more shifts before the key starts with no gap.
  always_comb begin
    state_d     = state_q;
    msg_shift   = 1'b0;
    key_shift   = 1'b0;
    load_result = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!CSS) begin
          msg_shift = 1'b1;
          state_d   = ST_LOAD_MSG;
        end
      end
      ST_LOAD_MSG: begin
        if (CSS) begin
          abort = 1'b1;
        end else begin
          msg_shift = 1'b1;
          if (cnt_q == MSG_LAST) state_d = ST_LOAD_KEY;
        end
      end
      ST_LOAD_KEY: begin
        if (CSS) begin
          abort = 1'b1;
        end else begin
          key_shift = 1'b1;
          if (cnt_q == KEY_LAST) state_d = ST_START;
        end
      end
      ST_START: begin
        if (CSS) abort = 1'b1;
        else     state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (CSS) begin
          abort = 1'b1;
        end else if (aes_done) begin
          load_result = 1'b1;
          state_d     = ST_SHIFT_OUT;
        end
      end
      ST_SHIFT_OUT: begin
        if (CSS) abort = 1'b1;
        else if (cnt_q == OUT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (CSS) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;

    if (state_d != state_q)     cnt_d = '0;
    else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
    else                        cnt_d = cnt_q + CNT_ONE;
  end

  // SOMI is registered one bit ahead: bit 0 comes straight from the core on
  // aes_done, later bits are fetched from the stored result by counter.
  assign out_idx = cnt_q[6:0] + 7'd1;

  always_comb begin
    somi_d = 1'b0;
    if (load_result) begin
      somi_d = aes_result[0];
    end else if (state_q == ST_SHIFT_OUT && state_d == ST_SHIFT_OUT) begin
      somi_d = result_q[out_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      result_q    <= '0;
      somi_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      somi_q      <= somi_d;
      frame_err_q <= abort;
      if (state_q == ST_IDLE && !CSS) mode_q <= mode;
      if (load_result) result_q <= aes_result;
    end
  end

  spi_shift_in #(.W(MSG_W)) u_msg_shift (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (msg_shift),
    .bit_i      (SIMO),
    .data_o     (aes_msg)
  );

  spi_shift_in #(.W(KEY_W)) u_key_shift (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (key_shift),
    .bit_i      (SIMO),
    .data_o     (aes_key)
  );

  // Status outputs are forced low while reset is held, not just after it.
  assign SOMI      = somi_q & ~reset;
  assign aes_start = (state_q == ST_START) & ~reset;
  assign aes_mode  = mode_q & ~reset;
  assign busy      = (state_q != ST_IDLE) & ~reset;
  assign frame_err = frame_err_q & ~reset;

endmodule

// File: tb/tb_spi_aes_slave.sv
// Directed bench for spi_aes_slave: an Nk=4 and an Nk=8 instance share the
// serial inputs and core model, each selected by its own chip select.
module tb_spi_aes_slave;

  localparam logic [127:0] MSG1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RES1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RES8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MSG3  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RES3  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BOGUS = 128'hdeadbeefcafef00d0badc0de12345678;

  logic         clk;
  logic         reset;
  logic         chipSel4, chipSel8;
  logic         simo, modeIn, aesDone;
  logic [127:0] aesResult;

  logic         somi4, aesStart4, aesMode4, busy4, frameErr4;
  logic [127:0] aesMsg4, aesKey4;
  logic         somi8, aesStart8, aesMode8, busy8, frameErr8;
  logic [127:0] aesMsg8;
  logic [255:0] aesKey8;

  int           assertCount;
  int           failCount;
  logic         earlyStart;
  logic         activity;
  logic         busyHeld;
  logic [127:0] gotResult;

  spi_aes_slave #(.Nk(4), .Nr(10)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .CSS        (chipSel4),
    .SIMO       (simo),
    .mode       (modeIn),
    .SOMI       (somi4),
    .aes_start  (aesStart4),
    .aes_mode   (aesMode4),
    .aes_msg    (aesMsg4),
    .aes_key    (aesKey4),
    .aes_done   (aesDone),
    .aes_result (aesResult),
    .busy       (busy4),
    .frame_err  (frameErr4)
  );

  spi_aes_slave #(.Nk(8), .Nr(14)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .CSS        (chipSel8),
    .SIMO       (simo),
    .mode       (modeIn),
    .SOMI       (somi8),
    .aes_start  (aesStart8),
    .aes_mode   (aesMode8),
    .aes_msg    (aesMsg8),
    .aes_key    (aesKey8),
    .aes_done   (aesDone),
    .aes_result (aesResult),
    .busy       (busy8),
    .frame_err  (frameErr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Clocks nBits frame bits in LSB first; optionally fires a stray aes_done.
  task automatic applyStimulus(input logic [383:0] bits, input int nBits,
                               input bit useWide, input int doneAtBit);
    earlyStart = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      if (useWide) chipSel8 = 1'b0;
      else         chipSel4 = 1'b0;
      simo = bits[i];
      if (i == doneAtBit) begin
        aesDone   = 1'b1;
        aesResult = BOGUS;
      end else begin
        aesDone   = 1'b0;
        aesResult = '0;
      end
      tick();
      if (i < nBits - 1) earlyStart = earlyStart | (useWide ? aesStart8 : aesStart4);
    end
    simo      = 1'b0;
    aesDone   = 1'b0;
    aesResult = '0;
  endtask

  // Core model: answers after waitCycles, then captures 128 SOMI bits.
  task automatic runCore(input int waitCycles, input logic [127:0] res, input bit useWide);
    for (int w = 0; w < waitCycles; w++) tick();
    aesDone   = 1'b1;
    aesResult = res;
    tick();
    aesDone   = 1'b0;
    aesResult = '0;
    for (int k = 0; k < 128; k++) begin
      gotResult[k] = useWide ? somi8 : somi4;
      tick();
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    chipSel4    = 1'b1;
    chipSel8    = 1'b1;
    simo        = 1'b0;
    modeIn      = 1'b0;
    aesDone     = 1'b0;
    aesResult   = '0;
    gotResult   = '0;

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("rst_busy", busy4, 0);
    checkOutput("rst_somi", somi4, 0);
    checkOutput("rst_start", aesStart4, 0);
    checkOutput("rst_mode", aesMode4, 0);
    checkOutput("rst_ferr", frameErr4, 0);
    checkOutput("rst_msg", aesMsg4, 0);
    reset = 1'b0;
    tick();

    $display("[TB] Nk=4 encrypt frame");
    modeIn = 1'b0;
    applyStimulus({128'h0, KEY1, MSG1}, 256, 1'b0, -1);
    checkOutput("n4_start_early", earlyStart, 0);
    checkOutput("n4_start_256", aesStart4, 1);
    checkOutput("n4_msg", aesMsg4, MSG1);
    checkOutput("n4_key", aesKey4, KEY1);
    checkOutput("n4_mode", aesMode4, 0);
    tick();
    checkOutput("n4_start_pulse", aesStart4, 0);
    checkOutput("n4_busy_wait", busy4, 1);
    runCore(4, RES1, 1'b0);
    checkOutput("n4_somi_stream", gotResult, RES1);

    $display("[TB] hold CSS low in DONE");
    activity = 1'b0;
    busyHeld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      activity = activity | somi4;
      busyHeld = busyHeld & busy4;
      tick();
    end
    checkOutput("done_somi_low", activity, 0);
    checkOutput("done_busy_high", busyHeld, 1);
    chipSel4 = 1'b1;
    tick();
    checkOutput("done_to_idle", busy4, 0);

    $display("[TB] Nk=8 decrypt frame");
    modeIn = 1'b1;
    applyStimulus({KEY8, MSG1}, 384, 1'b1, -1);
    checkOutput("n8_start_early", earlyStart, 0);
    checkOutput("n8_start_384", aesStart8, 1);
    checkOutput("n8_key", aesKey8, KEY8);
    checkOutput("n8_msg", aesMsg8, MSG1);
    checkOutput("n8_mode", aesMode8, 1);
    checkOutput("n4_idle_meanwhile", busy4, 0);
    modeIn = 1'b0;
    tick();
    checkOutput("n8_start_pulse", aesStart8, 0);
    runCore(3, RES8, 1'b1);
    checkOutput("n8_somi_stream", gotResult, RES8);
    checkOutput("n8_mode_held", aesMode8, 1);
    chipSel8 = 1'b1;
    tick();
    checkOutput("n8_idle", busy8, 0);
    checkOutput("n8_no_ferr", frameErr8, 0);

    $display("[TB] abort after 50 message bits");
    modeIn = 1'b0;
    applyStimulus({128'h0, KEY3, MSG3}, 50, 1'b0, -1);
    chipSel4 = 1'b1;
    tick();
    checkOutput("abort_ferr", frameErr4, 1);
    checkOutput("abort_idle", busy4, 0);
    tick();
    checkOutput("abort_ferr_pulse", frameErr4, 0);

    $display("[TB] full frame with stray aes_done in LOAD_KEY");
    applyStimulus({128'h0, KEY3, MSG3}, 256, 1'b0, 200);
    checkOutput("f3_start_early", earlyStart, 0);
    checkOutput("f3_start_256", aesStart4, 1);
    checkOutput("f3_msg", aesMsg4, MSG3);
    checkOutput("f3_key", aesKey4, KEY3);
    tick();
    runCore(19, RES3, 1'b0);
    checkOutput("f3_somi_stream", gotResult, RES3);
    chipSel4 = 1'b1;
    tick();
    checkOutput("f3_idle", busy4, 0);

    $display("[TB] reset in WAIT together with aes_done");
    modeIn = 1'b1;
    applyStimulus({128'h0, KEY1, MSG1}, 256, 1'b0, -1);
    tick();
    tick();
    checkOutput("w_busy_before", busy4, 1);
    reset     = 1'b1;
    aesDone   = 1'b1;
    aesResult = RES1;
    tick();
    checkOutput("wr_busy", busy4, 0);
    checkOutput("wr_start", aesStart4, 0);
    checkOutput("wr_mode", aesMode4, 0);
    checkOutput("wr_somi", somi4, 0);
    checkOutput("wr_ferr", frameErr4, 0);
    checkOutput("wr_msg", aesMsg4, 0);
    checkOutput("wr_key", aesKey4, 0);
    reset     = 1'b0;
    aesDone   = 1'b0;
    aesResult = '0;
    chipSel4  = 1'b1;
    activity  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      activity = activity | somi4 | frameErr4 | busy4;
    end
    checkOutput("wr_quiet_after", activity, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
